// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types and constants.
// Imported by the fetch stage and its slot storage.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic            vld;
        logic            filled;
        logic            misalign;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_nxt;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_slot_array.sv
// In-order slot storage for the fetch queue.
// Slots are allocated at the tail, filled oldest-first, popped at the head.
module fetch_slot_array
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  fetch_entry_t    push_entry,
    input  logic            pop,
    input  logic            fill,
    input  logic [ILEN-1:0] fill_instr,
    output fetch_entry_t    head_entry,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   pending,
    output logic            has_unfilled
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fill_idx;

    assign head_entry = mem[head];

    // Scan from youngest to oldest so the last hit is the oldest unfilled slot.
    always_comb begin
        has_unfilled = 1'b0;
        fill_idx     = head;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mem[head + PW'(i)].vld && !mem[head + PW'(i)].filled) begin
                has_unfilled = 1'b1;
                fill_idx     = head + PW'(i);
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int j = 0; j < DEPTH; j++) begin
            pending = pending + CW'(mem[j].vld & ~mem[j].filled);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fill && has_unfilled) begin
                mem[fill_idx].instr  <= fill_instr;
                mem[fill_idx].filled <= 1'b1;
            end
            if (pop) begin
                mem[head] <= '0;
                head      <= head + 1'b1;
            end
            // Push after pop: a full-queue push reuses the slot just freed.
            if (push) begin
                mem[tail] <= push_entry;
                tail      <= tail + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues in-order imem requests and queues
// {pc, pc_nxt, instr} for decode, discarding responses killed by a flush.
module fetch_queue
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_nxt_i,
    input  logic            flush_i,
    output logic            pc_adv_o,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_nxt,
    output logic [31:0]     id_instr,
    output logic            id_misalign,
    input  logic            id_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Drops can exceed DEPTH when flushes repeat while responses are pending.
    localparam int DW = CW + 1;

    fetch_entry_t  head;
    fetch_entry_t  new_entry;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic          has_unfilled;
    logic [DW-1:0] drop_cnt;

    logic aligned;
    logic pop;
    logic slot_free;
    logic mis_alloc;
    logic push;
    logic fill;

    assign aligned   = (pc_i[1:0] == 2'b00);
    assign id_valid  = head.vld & head.filled;
    assign pop       = id_valid & id_ready & ~flush_i;
    assign slot_free = (count < CW'(DEPTH)) | pop;

    assign imem_req_valid = ~rst & ~flush_i & slot_free & aligned;
    assign imem_req_addr  = rst ? '0 : pc_i;
    assign mis_alloc      = ~rst & ~flush_i & slot_free & ~aligned;
    assign push           = (imem_req_valid & imem_req_ready) | mis_alloc;
    assign pc_adv_o       = push;
    assign fill           = imem_rsp_valid & (drop_cnt == '0) & ~flush_i;

    assign id_pc       = head.pc;
    assign id_pc_nxt   = head.pc_nxt;
    assign id_instr    = head.instr;
    assign id_misalign = head.misalign;

    always_comb begin
        new_entry          = '0;
        new_entry.vld      = 1'b1;
        new_entry.filled   = ~aligned;
        new_entry.misalign = ~aligned;
        new_entry.pc       = pc_i;
        new_entry.pc_nxt   = pc_nxt_i;
    end

    fetch_slot_array #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_i),
        .push         (push),
        .push_entry   (new_entry),
        .pop          (pop),
        .fill         (fill),
        .fill_instr   (imem_rsp_data),
        .head_entry   (head),
        .count        (count),
        .pending      (pending),
        .has_unfilled (has_unfilled)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (flush_i) begin
            drop_cnt <= drop_cnt + DW'(pending) - DW'(imem_rsp_valid);
        end else if (imem_rsp_valid && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    a_rsp_orphan: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (drop_cnt != '0) || has_unfilled);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order imem model.
// Checks are immediate assertions at each directed step.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] pc_nxt_i;
    logic        flush_i;
    logic        pc_adv_o;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_nxt;
    logic [31:0] id_instr;
    logic        id_misalign;
    logic        id_ready;

    int npass = 0;
    int ntot  = 0;
    int lat   = 1;
    bit ok;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .pc_nxt_i       (pc_nxt_i),
        .flush_i        (flush_i),
        .pc_adv_o       (pc_adv_o),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_nxt      (id_pc_nxt),
        .id_instr       (id_instr),
        .id_misalign    (id_misalign),
        .id_ready       (id_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pend[$];
    int   tcnt;

    // In-order imem: response registered lat-1 edges after the accepting edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            tcnt           <= 0;
        end else begin
            if (imem_req_valid && imem_req_ready)
                pend.push_back('{imem_req_addr, tcnt + lat - 1});
            if (pend.size() > 0 && pend[0].due <= tcnt) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= instr_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            tcnt <= tcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic set_pc(input logic [31:0] a);
        pc_i     = a;
        pc_nxt_i = a + 32'd4;
    endtask

    // One clock; the PC register advances when the request was accepted.
    task automatic step();
        logic adv;
        adv = pc_adv_o;
        @(posedge clk);
        #1;
        if (adv) set_pc(pc_i + 32'd4);
        #1;
    endtask

    task automatic wait_id(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (id_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        flush_i        = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        set_pc(32'h0);
        #1;
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_pc_adv", {31'b0, pc_adv_o}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Test 1: streaming, one fetch per cycle.
        chk("t1_adv_a", {31'b0, pc_adv_o}, 32'd1);
        chk("t1_addr_a", imem_req_addr, 32'h0);
        step();
        chk("t1_adv_b", {31'b0, pc_adv_o}, 32'd1);
        chk("t1_nobypass", {31'b0, id_valid}, 32'd0);
        step();
        chk("t1_valid_c", {31'b0, id_valid}, 32'd1);
        chk("t1_pc_c", id_pc, 32'h0);
        chk("t1_instr_c", id_instr, instr_of(32'h0));
        chk("t1_adv_c", {31'b0, pc_adv_o}, 32'd1);
        step();
        chk("t1_pc_d", id_pc, 32'h4);
        chk("t1_instr_d", id_instr, instr_of(32'h4));
        chk("t1_adv_d", {31'b0, pc_adv_o}, 32'd1);
        step();
        chk("t1_pc_e", id_pc, 32'h8);
        chk("t1_nxt_e", id_pc_nxt, 32'hC);
        chk("t1_instr_e", id_instr, instr_of(32'h8));
        step();

        // Test 2: decode stall fills the queue, release drains in order.
        id_ready = 1'b0;
        #1;
        chk("t2_full_req", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_full_adv", {31'b0, pc_adv_o}, 32'd0);
        chk("t2_head", id_pc, 32'hC);
        step();
        chk("t2_still_full", {31'b0, imem_req_valid}, 32'd0);
        id_ready = 1'b1;
        #1;
        chk("t2_pop_pc", id_pc, 32'hC);
        chk("t2_resume_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t2_resume_addr", imem_req_addr, 32'h14);
        step();
        chk("t2_pc2", id_pc, 32'h10);
        chk("t2_instr2", id_instr, instr_of(32'h10));
        step();
        chk("t2_pc3", id_pc, 32'h14);
        chk("t2_instr3", id_instr, instr_of(32'h14));

        // Test 3: flush with two requests in flight.
        lat = 3;
        set_pc(32'h0);
        do_reset();
        step();
        step();
        chk("t3_two_inflight", {31'b0, imem_req_valid}, 32'd0);
        set_pc(32'h100);
        flush_i = 1'b1;
        #1;
        chk("t3_flush_noreq", {31'b0, imem_req_valid}, 32'd0);
        chk("t3_flush_noadv", {31'b0, pc_adv_o}, 32'd0);
        step();
        flush_i = 1'b0;
        #1;
        chk("t3_post_valid", {31'b0, id_valid}, 32'd0);
        chk("t3_new_addr", imem_req_addr, 32'h100);
        chk("t3_new_req", {31'b0, imem_req_valid}, 32'd1);
        wait_id(12, ok);
        chk("t3_timeout", {31'b0, ok}, 32'd1);
        chk("t3_pc", id_pc, 32'h100);
        chk("t3_instr", id_instr, instr_of(32'h100));

        // Test 4: flush in the cycle a response arrives.
        lat = 2;
        set_pc(32'h0);
        do_reset();
        step();
        step();
        chk("t4_rsp_now", {31'b0, imem_rsp_valid}, 32'd1);
        chk("t4_no_id", {31'b0, id_valid}, 32'd0);
        set_pc(32'h200);
        flush_i = 1'b1;
        #1;
        step();
        flush_i = 1'b0;
        #1;
        wait_id(12, ok);
        chk("t4_timeout", {31'b0, ok}, 32'd1);
        chk("t4_pc", id_pc, 32'h200);
        chk("t4_instr", id_instr, instr_of(32'h200));
        step();
        wait_id(12, ok);
        chk("t4_timeout2", {31'b0, ok}, 32'd1);
        chk("t4_pc2", id_pc, 32'h204);
        chk("t4_instr2", id_instr, instr_of(32'h204));

        // Test 5: misaligned PC allocates without an imem request.
        lat = 1;
        id_ready = 1'b0;
        set_pc(32'h102);
        do_reset();
        chk("t5_noreq", {31'b0, imem_req_valid}, 32'd0);
        chk("t5_adv", {31'b0, pc_adv_o}, 32'd1);
        step();
        chk("t5_valid", {31'b0, id_valid}, 32'd1);
        chk("t5_mis", {31'b0, id_misalign}, 32'd1);
        chk("t5_pc", id_pc, 32'h102);
        chk("t5_nxt", id_pc_nxt, 32'h106);
        chk("t5_instr", id_instr, 32'h0);
        step();
        chk("t5_full_adv", {31'b0, pc_adv_o}, 32'd0);

        // Test 6: asynchronous reset with a full queue.
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", {31'b0, id_valid}, 32'd0);
        chk("t6_pc", id_pc, 32'h0);
        chk("t6_mis", {31'b0, id_misalign}, 32'd0);
        chk("t6_req", {31'b0, imem_req_valid}, 32'd0);
        chk("t6_adv", {31'b0, pc_adv_o}, 32'd0);
        set_pc(32'h400);
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_req_after", {31'b0, imem_req_valid}, 32'd1);
        chk("t6_addr_after", imem_req_addr, 32'h400);
        wait_id(12, ok);
        chk("t6_timeout", {31'b0, ok}, 32'd1);
        chk("t6_pc_after", id_pc, 32'h400);
        chk("t6_instr_after", id_instr, instr_of(32'h400));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
